des_round_ctrl: RTL and testbench
=================================

// Module: des_round_ctrl
// PURPOSE
// Iterative single-DES engine controller: accepts a 64-bit block and 64-bit key, applies IP, sequences
// 16 Feistel rounds through one shared des_func instance (clk, dataIn, roundKey, dataOut), swaps and
// applies IP^-1. Generates round keys on the fly (PC1, per-round rotate, PC2), encrypt or decrypt.
// Building block for the 3DES EDE top; one block in flight at a time.
// PARAMETERS
// FUNC_LAT  1   cycles from stable dataIn/roundKey to valid des_func dataOut (>=1)
// PORTS
// clk        in   1   system clock, all logic rising-edge
// rst        in   1   synchronous, active-high reset
// in_valid   in   1   input block/key offered
// in_ready   out  1   controller can accept (high only in IDLE)
// in_decrypt in   1   1 = decrypt (reverse key order), sampled with in_block
// in_block   in   64  plaintext/ciphertext, bit 63 = DES bit 1
// in_key     in   64  DES key incl. parity bits (parity ignored)
// out_valid  out  1   result available, held until accepted
// out_ready  in   1   downstream accepts result
// out_block  out  64  result, stable while out_valid
// busy       out  1   high in any state except IDLE
// BEHAVIOUR
// - Reset: state=IDLE, in_ready=1, out_valid=0, out_block=0, busy=0, round counter=0, L/R/C/D regs=0.
// - FSM: IDLE -> ROUND -> WAIT -> (ROUND | FINAL) -> DONE -> IDLE.
//   IDLE: on in_valid&in_ready capture IP(in_block) into L0/R0, PC1(in_key) into C/D, mode; rnd=1.
//   ROUND: drive des_func dataIn=R, roundKey=PC2(C',D') where C',D' are this round's rotated halves.
//   WAIT: hold inputs FUNC_LAT cycles; then L<=R, R<=L^dataOut, commit C/D, rnd++.
//   After rnd 16 -> FINAL: out_block<=IP^-1({R16,L16}) (swap); DONE asserts out_valid.
//   DONE: out_valid held, out_block stable until out_valid&out_ready; then IDLE next cycle.
// - Key schedule, encrypt: rotate-left 1 in rounds 1,2,9,16, else 2, before PC2.
//   Decrypt: round 1 no rotation; rotate-right 1 in rounds 2,9,16, else 2 (yields K16..K1).
// - Latency: accept -> out_valid = 16*(FUNC_LAT+1)+2 cycles (34 at FUNC_LAT=1); throughput 1/(latency+1).
// - in_ready=0 outside IDLE; in_valid ignored then. out_ready outside DONE ignored.
// - Back-to-back: new block accepted only after DONE handshake completes (no overlap).
// - rst mid-operation: abandon block immediately, return to reset values next cycle; no partial output.
// - des_func inputs are held constant across WAIT; dataOut sampled only at WAIT exit.
// CONFIGURATION
// DES_ROUND_CTRL_DBG_EN defined: adds outputs dbg_round[4:0] (current rnd, 0 in IDLE) and
//   dbg_lr[63:0] ({L,R} after last committed round); updated on every round commit, 0 on reset.
// Not defined: ports absent, no debug registers; functional behaviour and latency identical.
// STRUCTURE
// - Shared package des_pkg: permutation tables IP, IP_INV, PC1, PC2 as constants/functions;
//   ROT_SCHED[1:16] shift amounts; FSM state encoding typedef; DES_ROUNDS=16.
// - One sub-module: des_func (existing f-function, E/S-box/P), instantiated once as u_func.
// - Key rotation and PC2 inline in this module; no separate key-schedule block.
// TESTING
// - FIPS vector: key 133457799BBCDFF1, block 0123456789ABCDEF, encrypt -> out_block 85E813540F0AB405.
// - Round-1 check: same vector, first ROUND cycle -> dataIn=F0AAF0AA, roundKey=1B02EFFC7072; f=234AA9BB.
// - Decrypt: key 133457799BBCDFF1, block 85E813540F0AB405, in_decrypt=1 -> 0123456789ABCDEF.
// - Backpressure: hold out_ready=0 for 20 cycles -> out_valid/out_block stable, in_ready stays 0;
//   in_valid pulses during busy are not accepted; release -> IDLE next cycle, in_ready=1.
// - Reset mid-block: assert rst at round 8 -> next cycle out_valid=0, busy=0, in_ready=1; following
//   FIPS vector completes correctly in 34 cycles.
// - FUNC_LAT=3 build: FIPS vector still 85E813540F0AB405, out_valid exactly 66 cycles after accept.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES constants: permutation/expansion tables, S-boxes, key rotation schedule and
// controller state encoding. Bit 63 of a 64-bit block is DES bit 1 throughout.
package des_pkg;

  localparam int DES_ROUNDS = 16;

  typedef enum logic [2:0] {S_IDLE, S_ROUND, S_WAIT, S_FINAL, S_DONE} state_t;

  localparam int ROT_SCHED [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int IP_INV_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Indexed [box][{row,col}], row = {b1,b6}, col = b2..b5
  localparam logic [3:0] S_T [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] ip_inv(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_INV_T[i]];
    return y;
  endfunction

  // Returns {C0, D0}; parity bits (8,16,..,64) are dropped by the table
  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [3:0] sbox(input int b, input logic [5:0] six);
    return S_T[b][{six[5], six[0], six[4:1]}];
  endfunction

  function automatic logic [1:0] rot_amt(input logic [4:0] r);
    if (r >= 5'd1 && r <= 5'd16) return 2'(ROT_SCHED[r]);
    return 2'd0;
  endfunction

endpackage

// File: rtl/des_func.sv
// DES f-function (E expansion, key mix, S-boxes, P) followed by LAT register stages,
// so dataOut reflects inputs that were stable LAT cycles earlier.
module des_func
  import des_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic [31:0] dataIn,
  input  logic [47:0] roundKey,
  output logic [31:0] dataOut
);

  logic [47:0]          x;
  logic [31:0]          s_out;
  logic [31:0]          f_comb;
  logic [LAT:1][31:0]   pipe;

  always_comb begin
    x     = e_exp(dataIn) ^ roundKey;
    s_out = '0;
    for (int b = 0; b < 8; b++) s_out[31-4*b -: 4] = sbox(b, x[47-6*b -: 6]);
    f_comb = p_perm(s_out);
  end

  always_ff @(posedge clk) begin
    pipe[1] <= f_comb;
    for (int i = 2; i <= LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign dataOut = pipe[LAT];

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative single-DES controller: 16 Feistel rounds through one shared des_func with the
// key schedule rotated on the fly. Define DES_ROUND_CTRL_DBG_EN for dbg_round/dbg_lr outputs.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int FUNC_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  input  logic [63:0] in_block,
  input  logic [63:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block,
  output logic        busy
`ifdef DES_ROUND_CTRL_DBG_EN
  ,
  output logic [4:0]  dbg_round,
  output logic [63:0] dbg_lr
`endif
);

  localparam logic [7:0] WAIT_LAST = 8'(FUNC_LAT - 1);

  state_t      state;
  logic [31:0] l_reg, r_reg;
  logic [27:0] c_reg, d_reg;
  logic        dec;
  logic [4:0]  rnd;
  logic [7:0]  wcnt;

  logic [1:0]  sh;
  logic [27:0] c_rot, d_rot;
  logic [47:0] rkey;
  logic [31:0] f_out;

  function automatic logic [27:0] rotl28(input logic [27:0] v, input logic [1:0] n);
    case (n)
      2'd1:    return {v[26:0], v[27]};
      2'd2:    return {v[25:0], v[27:26]};
      default: return v;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] v, input logic [1:0] n);
    case (n)
      2'd1:    return {v[0], v[27:1]};
      2'd2:    return {v[1:0], v[27:2]};
      default: return v;
    endcase
  endfunction

  // Decrypt walks the schedule backwards: C0/D0 already equal C16/D16, so round 1 is unrotated
  always_comb begin
    sh    = (dec && rnd == 5'd1) ? 2'd0 : rot_amt(rnd);
    c_rot = dec ? rotr28(c_reg, sh) : rotl28(c_reg, sh);
    d_rot = dec ? rotr28(d_reg, sh) : rotl28(d_reg, sh);
  end

  assign rkey = pc2({c_rot, d_rot});

  des_func #(.LAT(FUNC_LAT)) u_func (
    .clk      (clk),
    .dataIn   (r_reg),
    .roundKey (rkey),
    .dataOut  (f_out)
  );

`ifdef DES_ROUND_CTRL_DBG_EN
  assign dbg_round = rnd;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_block <= '0;
      busy      <= 1'b0;
      rnd       <= '0;
      wcnt      <= '0;
      dec       <= 1'b0;
      l_reg     <= '0;
      r_reg     <= '0;
      c_reg     <= '0;
      d_reg     <= '0;
`ifdef DES_ROUND_CTRL_DBG_EN
      dbg_lr    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            {l_reg, r_reg} <= ip(in_block);
            {c_reg, d_reg} <= pc1(in_key);
            dec            <= in_decrypt;
            rnd            <= 5'd1;
            in_ready       <= 1'b0;
            busy           <= 1'b1;
            state          <= S_ROUND;
          end
        end
        S_ROUND: begin
          wcnt  <= '0;
          state <= S_WAIT;
        end
        // r_reg and c/d stay untouched here, keeping des_func inputs constant until commit
        S_WAIT: begin
          if (wcnt == WAIT_LAST) begin
            l_reg <= r_reg;
            r_reg <= l_reg ^ f_out;
            c_reg <= c_rot;
            d_reg <= d_rot;
`ifdef DES_ROUND_CTRL_DBG_EN
            dbg_lr <= {r_reg, l_reg ^ f_out};
`endif
            if (rnd == 5'(DES_ROUNDS)) begin
              state <= S_FINAL;
            end else begin
              rnd   <= rnd + 5'd1;
              state <= S_ROUND;
            end
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        S_FINAL: begin
          out_block <= ip_inv({r_reg, l_reg});
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            rnd       <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: published DES vectors, cipher properties on random data
// (round trip, complementation, weak key), handshake timing, backpressure and reset.
module tb_des_round_ctrl;

  localparam int LAT     = 1;
  localparam int EXP_LAT = 16 * (LAT + 1) + 2;
  localparam int EXP_LAT3 = 16 * (3 + 1) + 2;

  localparam logic [63:0] FK = 64'h133457799BBCDFF1;
  localparam logic [63:0] FP = 64'h0123456789ABCDEF;
  localparam logic [63:0] FC = 64'h85E813540F0AB405;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
  logic [63:0] in_block, in_key, out_block;
  logic        in_valid3, in_ready3, out_valid3, busy3;
  logic [63:0] in_block3, out_block3;
`ifdef DES_ROUND_CTRL_DBG_EN
  logic [4:0]  dbg_round, dbg_round3;
  logic [63:0] dbg_lr, dbg_lr3;
`endif

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  des_round_ctrl #(.FUNC_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
    .in_block(in_block), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block), .busy(busy)
`ifdef DES_ROUND_CTRL_DBG_EN
    , .dbg_round(dbg_round), .dbg_lr(dbg_lr)
`endif
  );

  des_round_ctrl #(.FUNC_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_decrypt(1'b0),
    .in_block(in_block3), .in_key(FK), .out_valid(out_valid3), .out_ready(1'b1),
    .out_block(out_block3), .busy(busy3)
`ifdef DES_ROUND_CTRL_DBG_EN
    , .dbg_round(dbg_round3), .dbg_lr(dbg_lr3)
`endif
  );

  // Offer one block at a negedge; returns at the negedge right after the accepting edge
  task automatic start_block(input logic dec, input logic [63:0] key, input logic [63:0] blk);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL start_ready: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_decrypt = dec; in_key = key; in_block = blk;
    @(negedge clk);
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  // Latency = edges from the accepting edge to the edge where out_valid is first sampled high
  task automatic wait_result(output logic [63:0] res, output int lat);
    int t = 0;
    while (!out_valid && t < 400) begin @(negedge clk); t++; end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL result_timeout: out_valid=%b required 1", out_valid);
      res = 'x;
      lat = -1;
    end else begin
      res = out_block;
      lat = cyc - acc_cyc + 1;
      if (out_ready) @(negedge clk);
    end
  endtask

  task automatic run_block(input logic dec, input logic [63:0] key, input logic [63:0] blk,
                           output logic [63:0] res, output int lat);
    start_block(dec, key, blk);
    wait_result(res, lat);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_decrypt = 1'b0; in_block = '0; in_key = '0; out_ready = 1'b1;
    in_valid3 = 1'b0; in_block3 = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (out_block !== 64'h0) begin n_err++; $display("FAIL reset_out_block: got %h required 0", out_block); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++; if (in_ready3 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready3: got %b required 1", in_ready3); end
    rst = 1'b0;
  endtask

  task automatic test_fips_encrypt;
    logic [63:0] res; int lat;
    start_block(1'b0, FK, FP);
    n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL busy_after_accept: busy=%b in_ready=%b required 1/0", busy, in_ready); end
    n_cmp++; if (dut.u_func.dataIn !== 32'hF0AAF0AA) begin n_err++; $display("FAIL round1_dataIn: got %h required F0AAF0AA", dut.u_func.dataIn); end
    n_cmp++; if (dut.u_func.roundKey !== 48'h1B02EFFC7072) begin n_err++; $display("FAIL round1_key: got %h required 1B02EFFC7072", dut.u_func.roundKey); end
    repeat (LAT) @(negedge clk);
    n_cmp++; if (dut.u_func.dataOut !== 32'h234AA9BB) begin n_err++; $display("FAIL round1_f: got %h required 234AA9BB", dut.u_func.dataOut); end
    n_cmp++; if (dut.u_func.dataIn !== 32'hF0AAF0AA) begin n_err++; $display("FAIL round1_hold: got %h required F0AAF0AA", dut.u_func.dataIn); end
    wait_result(res, lat);
    n_cmp++; if (res !== FC) begin n_err++; $display("FAIL fips_encrypt: got %h required %h", res, FC); end
    n_cmp++; if (lat !== EXP_LAT) begin n_err++; $display("FAIL fips_latency: got %0d required %0d", lat, EXP_LAT); end
  endtask

  task automatic test_decrypt;
    logic [63:0] res; int lat;
    run_block(1'b1, FK, FC, res, lat);
    n_cmp++; if (res !== FP) begin n_err++; $display("FAIL fips_decrypt: got %h required %h", res, FP); end
    n_cmp++; if (lat !== EXP_LAT) begin n_err++; $display("FAIL decrypt_latency: got %0d required %0d", lat, EXP_LAT); end
  endtask

  task automatic test_known_vectors;
    logic [63:0] kv [4];
    logic [63:0] pv [4];
    logic [63:0] cv [4];
    logic [63:0] res; int lat;
    kv = '{64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h0E329232EA6D0D73, 64'h0123456789ABCDEF};
    pv = '{64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8787878787878787, 64'h4E6F772069732074};
    cv = '{64'h8CA64DE9C1B123A7, 64'h7359B2163E4EDC58, 64'h0000000000000000, 64'h3FA40E8A984D4815};
    for (int i = 0; i < 4; i++) begin
      run_block(1'b0, kv[i], pv[i], res, lat);
      n_cmp++; if (res !== cv[i]) begin n_err++; $display("FAIL known_enc[%0d]: got %h required %h", i, res, cv[i]); end
      run_block(1'b1, kv[i], cv[i], res, lat);
      n_cmp++; if (res !== pv[i]) begin n_err++; $display("FAIL known_dec[%0d]: got %h required %h", i, res, pv[i]); end
    end
  endtask

  // Random data checked through cipher identities: D_k(E_k(p)) = p,
  // E_~k(~p) = ~E_k(p), and E_w(E_w(p)) = p for the weak key w
  task automatic test_random_props;
    logic [63:0] p, k, c, res, x; int lat;
    for (int i = 0; i < 4; i++) begin
      p = {$urandom, $urandom};
      k = {$urandom, $urandom};
      run_block(1'b0, k, p, c, lat);
      n_cmp++; if (lat !== EXP_LAT) begin n_err++; $display("FAIL rand_latency[%0d]: got %0d required %0d", i, lat, EXP_LAT); end
      run_block(1'b1, k, c, res, lat);
      n_cmp++; if (res !== p) begin n_err++; $display("FAIL rand_roundtrip[%0d]: got %h required %h", i, res, p); end
      run_block(1'b0, ~k, ~p, res, lat);
      n_cmp++; if (res !== ~c) begin n_err++; $display("FAIL rand_complement[%0d]: got %h required %h", i, res, ~c); end
      run_block(1'b0, 64'h0101010101010101, p, x, lat);
      run_block(1'b0, 64'h0101010101010101, x, res, lat);
      n_cmp++; if (res !== p) begin n_err++; $display("FAIL rand_weakkey[%0d]: got %h required %h", i, res, p); end
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] res; int lat;
    out_ready = 1'b0;
    start_block(1'b0, FK, FP);
    repeat (5) @(negedge clk);
    in_valid = 1'b1; in_block = {$urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(res, lat);
    n_cmp++; if (res !== FC) begin n_err++; $display("FAIL bp_result: got %h required %h", res, FC); end
    n_cmp++; if (lat !== EXP_LAT) begin n_err++; $display("FAIL bp_latency: got %0d required %0d", lat, EXP_LAT); end
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0]; in_block = {$urandom, $urandom};
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_block !== FC || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: out_valid=%b out_block=%h in_ready=%b required 1/%h/0", i, out_valid, out_block, in_ready, FC);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] ra, res; int acc_a, acc_b, t, lat; bit got_a;
    t = 0; got_a = 0; ra = '0;
    @(negedge clk);
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    in_valid = 1'b1; in_decrypt = 1'b0; in_key = FK; in_block = FP;
    @(negedge clk);
    acc_a = cyc;
    in_decrypt = 1'b1; in_block = FC;
    t = 0;
    while (!in_ready && t < 200) begin
      if (out_valid) begin ra = out_block; got_a = 1'b1; end
      @(negedge clk); t++;
    end
    @(negedge clk);
    acc_b = cyc;
    acc_cyc = acc_b;
    in_valid = 1'b0;
    n_cmp++; if (!got_a || ra !== FC) begin n_err++; $display("FAIL b2b_first: got %h (seen=%0d) required %h", ra, got_a, FC); end
    n_cmp++; if (acc_b - acc_a !== EXP_LAT + 1) begin n_err++; $display("FAIL b2b_spacing: got %0d required %0d", acc_b - acc_a, EXP_LAT + 1); end
    wait_result(res, lat);
    n_cmp++; if (res !== FP) begin n_err++; $display("FAIL b2b_second: got %h required %h", res, FP); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] res; int lat;
    start_block(1'b0, FK, FP);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: out_valid=%b busy=%b in_ready=%b required 0/0/1", out_valid, busy, in_ready);
    end
    run_block(1'b0, FK, FP, res, lat);
    n_cmp++; if (res !== FC) begin n_err++; $display("FAIL post_reset_result: got %h required %h", res, FC); end
    n_cmp++; if (lat !== EXP_LAT) begin n_err++; $display("FAIL post_reset_latency: got %0d required %0d", lat, EXP_LAT); end
  endtask

  task automatic test_lat3;
    int t, acc, lat;
    t = 0;
    @(negedge clk);
    while (!in_ready3 && t < 100) begin @(negedge clk); t++; end
    in_valid3 = 1'b1; in_block3 = FP;
    @(negedge clk);
    acc = cyc;
    in_valid3 = 1'b0;
    t = 0;
    while (!out_valid3 && t < 400) begin @(negedge clk); t++; end
    lat = cyc - acc + 1;
    n_cmp++; if (out_valid3 !== 1'b1 || out_block3 !== FC) begin n_err++; $display("FAIL lat3_result: valid=%b got %h required %h", out_valid3, out_block3, FC); end
    n_cmp++; if (lat !== EXP_LAT3) begin n_err++; $display("FAIL lat3_latency: got %0d required %0d", lat, EXP_LAT3); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_fips_encrypt;
    test_decrypt;
    test_known_vectors;
    test_random_props;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_lat3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
